// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline memory stage: FSM states, control-bit
// positions, MEM/WB control packing and stage defaults.
package mips_pipe_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_BEQ        = 5;
  localparam int CTRL_BNE        = 4;
  localparam int CTRL_ZERO       = 3;
  localparam int CTRL_J          = 2;
  localparam int CTRL_JAL        = 1;
  localparam int CTRL_JR         = 0;

  localparam int WB_REG_WRITE  = 2;
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_JAL        = 0;

  localparam int         TIMEOUT_DEF = 16;
  localparam logic [4:0] RA_REG      = 5'd31;

  function automatic logic [2:0] wb_ctrl_of(input logic [9:0] c);
    logic [2:0] w;
    w                = '0;
    w[WB_REG_WRITE]  = c[CTRL_REG_WRITE];
    w[WB_MEM_TO_REG] = c[CTRL_MEM_TO_REG];
    w[WB_JAL]        = c[CTRL_JAL];
    return w;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble takes priority over load, otherwise it holds.
module mem_wb_reg
  import mips_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] read_data_d,
  input  logic [31:0] alu_result_d,
  input  logic [4:0]  write_reg_d,
  input  logic [2:0]  ctrl_d,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_write_reg,
  output logic [2:0]  wb_ctrl
);

  logic [31:0] read_data_q;
  logic [31:0] alu_result_q;
  logic [4:0]  write_reg_q;
  logic [2:0]  ctrl_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      ctrl_q       <= '0;
    end else if (bubble) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      ctrl_q       <= '0;
    end else if (load) begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign wb_read_data  = read_data_q;
  assign wb_alu_result = alu_result_q;
  assign wb_write_reg  = write_reg_q;
  assign wb_ctrl       = ctrl_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS MEM stage: branch/jump redirect, wait-state data-memory handshake with
// timeout, upstream stall generation and the MEM/WB register.
module mem_stage_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [31:0] target_addr,
  input  logic [4:0]  write_reg,
  input  logic [9:0]  ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] target_pc,
  output logic        flush,
  output logic        bus_error,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_write_reg,
  output logic [2:0]  wb_ctrl
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rdata_q;
  logic              fail_q;
  logic              bus_error_q;

  logic              mem_op;
  logic              taken;
  logic              wb_load;
  logic              wb_bubble;
  logic [31:0]       wb_rdata_d;
  logic [4:0]        wb_reg_d;

  assign mem_op = ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];
  assign taken  = (ctrl[CTRL_BEQ] & ctrl[CTRL_ZERO]) | (ctrl[CTRL_BNE] & ~ctrl[CTRL_ZERO])
                | ctrl[CTRL_J] | ctrl[CTRL_JAL] | ctrl[CTRL_JR];

  // A memory access always wins over a coincident redirect.
  always_comb begin
    stall  = 1'b0;
    pc_src = 1'b0;
    flush  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall  = mem_op;
        pc_src = taken & ~mem_op;
        flush  = taken & ~mem_op;
      end
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign target_pc = target_addr;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      fail_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= ctrl[CTRL_MEM_WRITE];
            mem_addr_q  <= alu_result;
            mem_wdata_q <= write_data;
            cnt_q       <= '0;
            fail_q      <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q   <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_q   <= 1'b0;
            bus_error_q <= 1'b1;
            fail_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_error = bus_error_q;

  // Only a completed access carries read data; everything else writes back zero.
  assign wb_load    = ((state_q == IDLE) & ~mem_op) | ((state_q == DONE) & ~fail_q);
  assign wb_bubble  = ((state_q == IDLE) &  mem_op) | ((state_q == DONE) &  fail_q);
  assign wb_rdata_d = (state_q == DONE) ? rdata_q : '0;
  assign wb_reg_d   = ctrl[CTRL_JAL] ? RA_REG : write_reg;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .read_data_d  (wb_rdata_d),
    .alu_result_d (alu_result),
    .write_reg_d  (wb_reg_d),
    .ctrl_d       (wb_ctrl_of(ctrl)),
    .wb_read_data (wb_read_data),
    .wb_alu_result(wb_alu_result),
    .wb_write_reg (wb_write_reg),
    .wb_ctrl      (wb_ctrl)
  );

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-access stage of the 5-stage MIPS pipeline, placed directly downstream of the EX/MEM pipeline register and feeding the write-back stage. It resolves branches and jumps (PC redirect plus flush) and runs a wait-state data-memory handshake with timeout. While an access is outstanding it stalls the upstream pipeline. It also contains the MEM/WB pipeline register.

## Interface
- TIMEOUT, 16: maximum BUSY cycles to wait for `mem_ack` before a bus error; must be ≥2.
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers.
- reset  in  1  reset, asynchronous, active-low.
- alu_result  in  32  EX/MEM ALU result: memory address, or return address for JAL.
- write_data  in  32  EX/MEM rt data (store data).
- target_addr  in  32  EX/MEM branch target; carries the jump target for J/JR/JAL.
- write_reg  in  5  EX/MEM destination register (31 for JAL, set by EX).
- ctrl  in  10  EX/MEM control, bit 9..0 = {reg_write, mem_to_reg, mem_read, mem_write, beq, bne, zero, j, jal, jr}.
- mem_rdata  in  32  data-memory read data, valid when `mem_ack`=1.
- mem_ack  in  1  data-memory completion.
- mem_req  out  1  registered access request.
- mem_we  out  1  registered write enable (store).
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (drives their enables low).
- pc_src  out  1  select `target_pc` as next PC.
- target_pc  out  32  redirect address.
- flush  out  1  bubble IF/ID, ID/EX and EX/MEM on the next edge.
- bus_error  out  1  sticky timeout flag.
- wb_read_data  out  32  MEM/WB load data.
- wb_alu_result  out  32  MEM/WB ALU result or return address.
- wb_write_reg  out  5  MEM/WB destination register.
- wb_ctrl  out  3  MEM/WB {reg_write, mem_to_reg, jal}.

## Operation
- `mem_op` = mem_read | mem_write. `taken` = (beq & zero) | (bne & ~zero) | j | jal | jr.
- States:
  - IDLE: `stall` = `mem_op`. If `taken` and not `mem_op`: `pc_src`=1, `flush`=1, `target_pc`=`target_addr` (combinational). If `mem_op`, on the edge: latch `mem_addr`/`mem_wdata`/`mem_we`, set `mem_req`=1, clear the wait counter, go to BUSY, and MEM/WB loads a bubble (all `wb_*` = 0). Otherwise MEM/WB loads the EX/MEM fields; state stays IDLE.
  - BUSY: `stall`=1, `pc_src`=0, `flush`=0. MEM/WB holds its value.
    - Edge with `mem_ack`=1: capture `mem_rdata`, `mem_req`=0, go to DONE.
    - Else, when the counter reaches TIMEOUT-1: `mem_req`=0, `bus_error`=1, mark the access failed, go to DONE.
    - Else: counter +1.
  - DONE: `stall`=0, so EX/MEM advances on this edge. MEM/WB loads the instruction with the captured data as `wb_read_data`; on a failed access it loads a bubble instead. Go to IDLE.
- Store: `wb_ctrl.reg_write` passes through as 0. Load write-back uses the captured data, never live `mem_rdata`.
- A branch/jump never coexists with `mem_op`. If both are set, the memory access wins and no redirect occurs.
- `mem_ack` outside BUSY is ignored.
- `bus_error` clears only on reset.

## Timing
- Reset (async, any state, including mid-BUSY): state=IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, all `wb_*`, `bus_error` and the counter = 0. Combinational outputs follow IDLE rules.
- Zero-wait memory (`mem_ack` high in the first BUSY cycle): 2 stall cycles. The load appears on `wb_*` 3 falling edges after entering MEM.
- N wait cycles: N+2 stall cycles.
- Redirect: `pc_src`/`flush` are high for exactly one cycle, the cycle the branch sits in EX/MEM. The flush takes effect on the same falling edge the PC loads `target_pc`.
- `mem_req` is stable from the IDLE→BUSY edge to the ack edge. `mem_addr`/`mem_wdata`/`mem_we` are stable for the entire BUSY period.

## Structure
- Shared package `mips_pipe_pkg`: state enum (IDLE/BUSY/DONE), `ctrl` and `wb_ctrl` bit-index constants, TIMEOUT default, RA register constant 5'd31.
- Sub-module `mem_wb_reg`: the MEM/WB register with load/bubble/hold controls from the FSM.

## Test plan
- Load, `alu_result`=0x1001_0004, `mem_ack` on the first BUSY cycle, `mem_rdata`=0xDEAD_BEEF -> `stall` high 2 cycles; `wb_read_data`=0xDEAD_BEEF, `wb_ctrl`=3'b110.
- Store with `mem_ack` after 5 BUSY cycles -> `mem_we`=1 and `mem_wdata` held 5 cycles; `stall` high 7 cycles; `wb_ctrl.reg_write`=0.
- Load with no ack, TIMEOUT=16 -> `mem_req` drops after 16 BUSY cycles; `bus_error`=1 sticky; bubble in MEM/WB.
- beq with zero=1, `target_addr`=0x0040_0020 -> one cycle of `pc_src`=1, `flush`=1, `target_pc`=0x0040_0020. bne with zero=1 -> no redirect.
- jal, `alu_result`=0x0040_0008, `write_reg`=31 -> redirect, then `wb_alu_result`=0x0040_0008, `wb_ctrl`=3'b101.
- Reset asserted mid-BUSY -> `mem_req`=0 immediately; state IDLE; `bus_error`=0; next load proceeds normally.
